// File: rtl/fifo_word_packer_pkg.sv
// fifo_word_packer_pkg: shared lane mapping, byte-enable mask and flush FSM encoding
package fifo_word_packer_pkg;
   localparam int LANES_DEF = 4;
   localparam int MAXL = 64;
   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;
   function automatic int lane_of(input int idx, input int lanes, input bit big);
      return big ? lanes - 1 - idx : idx;
   endfunction
   function automatic logic [MAXL-1:0] be_mask(input int cnt, input int lanes, input bit big);
      logic [MAXL-1:0] m;
      m = '0;
      for (int i = 0; i < MAXL; i++) m[i] = (i < lanes) && (lane_of(i, lanes, big) < cnt);
      return m;
   endfunction
endpackage

// File: rtl/fifo_word_packer_byte_lane_accum.sv
// byte_lane_accum: collects popped bytes into lanes of the word under construction
module byte_lane_accum
   import fifo_word_packer_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           capture,
   input  logic                           clear,
   input  logic [7:0]                     data,
   output logic [8*LANES-1:0]             acc,
   output logic [$clog2(LANES+1)-1:0]     acc_cnt
);
   localparam int CW = $clog2(LANES + 1);
   int wr_lane;
   assign wr_lane = lane_of(clear ? 0 : int'(acc_cnt), LANES, BIG_ENDIAN);
   // A transfer empties the word; a byte landing in the same cycle starts the next word
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         acc <= '0;
         acc_cnt <= '0;
      end else begin
         for (int i = 0; i < LANES; i++)
            if (capture && i == wr_lane) acc[8*i +: 8] <= data;
            else if (clear) acc[8*i +: 8] <= '0;
         acc_cnt <= (clear ? '0 : acc_cnt) + CW'(capture);
      end
endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops bytes from a byte FIFO and emits packed words on valid/ready
module fifo_word_packer
   import fifo_word_packer_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 empty,
   input  logic                 wr_block,
   input  logic [7:0]           fifo_data,
   output logic                 rn,
   input  logic                 flush,
   output logic [8*LANES-1:0]   word_out,
   output logic [LANES-1:0]     byte_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy
);
   localparam int CW = $clog2(LANES + 1);
   state_t state, state_nxt;
   logic pend, flush_req, clear, xfer_full, xfer_part, slot_free, ov_nxt;
   logic [8*LANES-1:0] acc;
   logic [CW-1:0] acc_cnt;
   int cnt_nxt;

   byte_lane_accum #(.LANES(LANES), .BIG_ENDIAN(BIG_ENDIAN)) u_accum (
      .clock(clock), .reset(reset), .capture(pend), .clear(clear),
      .data(fifo_data), .acc(acc), .acc_cnt(acc_cnt)
   );

   assign busy = acc_cnt != '0 || pend || flush_req || out_valid;

   // Transfer decode, read issue (a read may target a slot freed by a guaranteed transfer) and FSM
   always_comb begin
      slot_free = !out_valid || out_ready;
      xfer_full = int'(acc_cnt) == LANES && slot_free;
      xfer_part = state == DRAIN && !pend && acc_cnt != '0 && int'(acc_cnt) != LANES && slot_free;
      clear = xfer_full || xfer_part;
      ov_nxt = clear || (out_valid && !out_ready);
      cnt_nxt = (clear ? 0 : int'(acc_cnt)) + int'(pend);
      rn = reset && state == FILL && !empty && !wr_block &&
           (cnt_nxt < LANES || (cnt_nxt == LANES && !ov_nxt));
      state_nxt = state == FILL ? (flush ? DRAIN : FILL) :
                  (!pend && (acc_cnt == '0 || xfer_part)) ? FILL : DRAIN;
   end

   // FSM state, in-flight read flag and pending flush request
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state <= FILL;
         pend <= 1'b0;
         flush_req <= 1'b0;
      end else begin
         state <= state_nxt;
         pend <= rn;
         flush_req <= state_nxt == DRAIN;
      end

   // Output register: loads on a transfer and holds until the consumer accepts
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         word_out <= '0;
         byte_en <= '0;
         out_valid <= 1'b0;
      end else if (clear) begin
         word_out <= acc;
         byte_en <= xfer_full ? '1 : LANES'(be_mask(int'(acc_cnt), LANES, BIG_ENDIAN));
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: table vectors, directed corner sequences and randomized scoreboard run
module tb_fifo_word_packer;
   localparam int L = 4;
   typedef struct {logic [31:0] w; logic [3:0] be;} wd_t;
   typedef struct {logic [31:0] w; logic [3:0] be; logic [31:0] w2; logic [3:0] be2;} obs_t;
   typedef struct {int n; logic [31:0] b; bit fl; logic [31:0] w; logic [3:0] be; logic [31:0] wb; logic [3:0] beb;} vec_t;

   logic clock = 1'b0, reset = 1'b0;
   logic empty = 1'b1, wr_block = 1'b0, flush = 1'b0, out_ready = 1'b1;
   logic [7:0] fifo_data = '0;
   logic rn, rn2, out_valid, out_valid2, busy, busy2;
   logic [31:0] word_out, word_out2;
   logic [3:0] byte_en, byte_en2;

   fifo_word_packer #(.LANES(L), .BIG_ENDIAN(1'b0)) dut (
      .clock(clock), .reset(reset), .empty(empty), .wr_block(wr_block), .fifo_data(fifo_data),
      .rn(rn), .flush(flush), .word_out(word_out), .byte_en(byte_en), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );
   fifo_word_packer #(.LANES(L), .BIG_ENDIAN(1'b1)) dut_be (
      .clock(clock), .reset(reset), .empty(empty), .wr_block(wr_block), .fifo_data(fifo_data),
      .rn(rn2), .flush(flush), .word_out(word_out2), .byte_en(byte_en2), .out_valid(out_valid2),
      .out_ready(out_ready), .busy(busy2)
   );

   always #5 clock = ~clock;

   bit f_rstn = 0, f_empty = 0, f_wrb = 0, f_flush = 0, f_ready = 1;
   logic [7:0] src[$];
   logic [7:0] part[$];
   wd_t exp_q[$];
   obs_t log_q[$];
   logic [7:0] nxt_data = '0;
   bit nxt_vld = 0, hold_prev = 0, last_ov = 0, last_busy = 0, rn_last = 0;
   logic [31:0] prev_w = '0, last_w = '0;
   logic [3:0] prev_be = '0;
   int checks = 0, errors = 0, rn_cnt = 0;
   vec_t tbl[4];

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", nm, act, req);
      end
   endfunction

   function automatic logic [31:0] mir_w(logic [31:0] w);
      logic [31:0] r;
      for (int i = 0; i < L; i++) r[8*(L-1-i) +: 8] = w[8*i +: 8];
      return r;
   endfunction

   function automatic logic [3:0] mir_be(logic [3:0] b);
      logic [3:0] r;
      for (int i = 0; i < L; i++) r[L-1-i] = b[i];
      return r;
   endfunction

   // Model: popped bytes are grouped into words of L; a flush cuts the partial group
   function automatic void cut();
      wd_t e;
      if (part.size() == 0) return;
      e.w = '0;
      for (int i = 0; i < part.size(); i++) e.w = e.w | (32'(part[i]) << (8 * i));
      e.be = 4'((1 << part.size()) - 1);
      exp_q.push_back(e);
      part.delete();
   endfunction

   function automatic void push_byte(logic [7:0] b);
      part.push_back(b);
      if (part.size() == L) cut();
   endfunction

   task automatic tick();
      obs_t o;
      wd_t e;
      @(negedge clock);
      reset = f_rstn;
      empty = f_empty || src.size() == 0;
      wr_block = f_wrb;
      flush = f_flush;
      out_ready = f_ready;
      fifo_data = nxt_vld ? nxt_data : 8'($urandom);
      #1;
      if (!reset) begin
         chk("rst_rn", rn, 0);
         chk("rst_valid", out_valid, 0);
         chk("rst_word", word_out, 0);
         chk("rst_be", byte_en, 0);
         chk("rst_busy", busy, 0);
         part.delete();
         exp_q.delete();
         nxt_vld = 0;
         hold_prev = 0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_word", word_out, prev_w);
            chk("hold_be", byte_en, prev_be);
         end
         if (rn && (empty || wr_block)) chk("rn_gate", rn, 0);
         if (rn2 && (empty || wr_block)) chk("rn_gate_be", rn2, 0);
         nxt_vld = rn && src.size() != 0;
         if (nxt_vld) begin
            nxt_data = src.pop_front();
            push_byte(nxt_data);
            rn_cnt++;
         end
         if (flush) cut();
         if (out_valid && out_ready) begin
            o = '{word_out, byte_en, word_out2, byte_en2};
            log_q.push_back(o);
            chk("word_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sb_word", word_out, e.w);
               chk("sb_be", byte_en, e.be);
               chk("sb_valid_be", out_valid2, 1);
               chk("sb_word_be", word_out2, mir_w(e.w));
               chk("sb_be_be", byte_en2, mir_be(e.be));
            end
         end
         hold_prev = out_valid && !out_ready;
      end
      prev_w = word_out;
      prev_be = byte_en;
      last_ov = out_valid;
      last_w = word_out;
      last_busy = busy;
      rn_last = rn;
   endtask

   task automatic wait_words(int n, int budget);
      for (int i = 0; i < budget && log_q.size() < n; i++) tick();
      if (log_q.size() < n) chk("timeout_words", log_q.size(), n);
   endtask

   initial begin
      logic [15:0] rnv;
      int since;
      tbl[0] = '{4, 32'h11223344, 1'b0, 32'h44332211, 4'hF, 32'h11223344, 4'hF};
      tbl[1] = '{3, 32'hA1B2C300, 1'b1, 32'h00C3B2A1, 4'h7, 32'hA1B2C300, 4'hE};
      tbl[2] = '{1, 32'h5A000000, 1'b1, 32'h0000005A, 4'h1, 32'h5A000000, 4'h8};
      tbl[3] = '{2, 32'hDEAD0000, 1'b1, 32'h0000ADDE, 4'h3, 32'hDEAD0000, 4'hC};
      repeat (2) tick();
      f_rstn = 1;
      tick();
      for (int r = 0; r < 4; r++) begin
         log_q.delete();
         for (int i = 0; i < tbl[r].n; i++) src.push_back(tbl[r].b[8*(3-i) +: 8]);
         repeat (6) tick();
         if (tbl[r].fl) begin
            f_flush = 1;
            tick();
            f_flush = 0;
         end
         wait_words(1, 12);
         if (log_q.size() != 0) begin
            chk($sformatf("tbl%0d_word", r), log_q[0].w, tbl[r].w);
            chk($sformatf("tbl%0d_be", r), log_q[0].be, tbl[r].be);
            chk($sformatf("tbl%0d_word_be", r), log_q[0].w2, tbl[r].wb);
            chk($sformatf("tbl%0d_be_be", r), log_q[0].be2, tbl[r].beb);
         end
         repeat (3) tick();
      end
      log_q.delete();
      for (int i = 1; i <= 8; i++) src.push_back(8'(i));
      for (int i = 0; i < 16; i++) begin
         tick();
         rnv[i] = rn_last;
      end
      chk("stream_rn", rnv, 16'h00FF);
      chk("stream_words", log_q.size(), 2);
      if (log_q.size() == 2) begin
         chk("stream_w0", log_q[0].w, 32'h04030201);
         chk("stream_w1", log_q[1].w, 32'h08070605);
      end
      log_q.delete();
      f_flush = 1;
      tick();
      f_flush = 0;
      tick();
      chk("flush_idle_busy_hi", last_busy, 1);
      repeat (2) tick();
      chk("flush_idle_busy_lo", last_busy, 0);
      chk("flush_idle_words", log_q.size(), 0);
      f_ready = 0;
      rn_cnt = 0;
      for (int i = 0; i < 12; i++) src.push_back(8'(8'h21 + i));
      repeat (16) tick();
      chk("stall_rn_cnt", rn_cnt, 8);
      chk("stall_valid", last_ov, 1);
      chk("stall_word", last_w, 32'h24232221);
      chk("stall_busy", last_busy, 1);
      f_ready = 1;
      tick();
      tick();
      chk("stall_next_valid", last_ov, 1);
      chk("stall_next_word", last_w, 32'h28272625);
      wait_words(3, 20);
      if (log_q.size() >= 3) chk("stall_w2", log_q[2].w, 32'h2C2B2A29);
      repeat (3) tick();
      log_q.delete();
      rn_cnt = 0;
      for (int i = 0; i < 4; i++) src.push_back(8'(8'h10 + i));
      for (int i = 0; i < 12; i++) begin
         f_wrb = i % 2 == 0;
         tick();
      end
      f_wrb = 0;
      wait_words(1, 10);
      chk("wrb_rn_cnt", rn_cnt, 4);
      chk("wrb_words", log_q.size(), 1);
      if (log_q.size() != 0) chk("wrb_word", log_q[0].w, 32'h13121110);
      log_q.delete();
      for (int i = 0; i < 8; i++) src.push_back(8'(8'h60 + i));
      repeat (3) tick();
      f_rstn = 0;
      tick();
      f_rstn = 1;
      wait_words(1, 20);
      if (log_q.size() != 0) chk("rst_fresh_word", log_q[0].w, 32'h66656463);
      repeat (3) tick();
      f_flush = 1;
      tick();
      f_flush = 0;
      wait_words(2, 10);
      if (log_q.size() >= 2) chk("rst_tail_word", log_q[1].w, 32'h00000067);
      since = 0;
      for (int c = 0; c < 3000; c++) begin
         if (src.size() < 16 && $urandom_range(0, 3) != 0) src.push_back(8'($urandom));
         f_empty = $urandom_range(0, 4) == 0;
         f_wrb = $urandom_range(0, 2) == 0;
         f_ready = $urandom_range(0, 9) < 7;
         f_flush = exp_q.size() == 0 && since >= 3 && $urandom_range(0, 19) == 0;
         since = f_flush ? 0 : since + 1;
         tick();
      end
      f_flush = 0;
      f_empty = 1;
      f_wrb = 0;
      f_ready = 1;
      repeat (20) tick();
      f_flush = 1;
      tick();
      f_flush = 0;
      repeat (10) tick();
      chk("final_exp_empty", exp_q.size(), 0);
      chk("final_busy", last_busy, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
